clock_mode_ctrl: RTL and testbench
==================================

Name: clock_mode_ctrl

Overview:
Mode and timekeeping controller for the digital clock. It consumes the single-cycle 1 Hz and 5 Hz tick pulses from the frequency divider and debounced button pulses. It sequences RUN/SET modes and holds the hh:mm:ss time registers. It drives field-visibility (blink) flags to the 7-segment display driver.

Parameters:
TIMEOUT_S, 30, seconds of button inactivity in any SET state before auto-return to RUN; 0 disables the timeout.
TO_W, 6, width of the timeout counter; must satisfy 2**TO_W > TIMEOUT_S.

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  reset; asynchronous, active-low
tick_1hz  in  1  one-clk pulse per second from the divider
tick_5hz  in  1  one-clk pulse every 200 ms from the divider
btn_mode  in  1  debounced one-clk pulse; advances the mode
btn_inc  in  1  debounced one-clk pulse; increments the selected field
btn_inc_lvl  in  1  debounced level of the increment key; used only with HOLD_REPEAT_EN
hour  out  5  0..23
minute  out  6  0..59
second  out  6  0..59
mode  out  2  0=RUN, 1=SET_HR, 2=SET_MIN, 3=SET_SEC
hr_vis, min_vis, sec_vis  out  1 each  1 = field lit; 0 = blanked (blink)
day_tick  out  1  one-clk pulse on the 23:59:59 -> 00:00:00 rollover

Behaviour:
- Reset values: state RUN, time 00:00:00, mode=0, all *_vis=1, day_tick=0, blink_phase=1, timeout counter 0.
- All outputs are registered. An event sampled at edge N is visible after edge N.
- RUN: on tick_1hz, second increments.
  - 59 -> 0 carries to minute; minute 59 -> 0 carries to hour; hour 23 -> 0.
  - The full rollover 23:59:59 -> 00:00:00 pulses day_tick for exactly one clk.
- FSM on btn_mode: RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN.
- SET states: tick_1hz does not advance time; time is frozen.
- btn_inc in a SET state increments only the selected field, modulo its range, with no carry:
  - SET_HR: 23 -> 0.
  - SET_MIN: 59 -> 0.
  - SET_SEC: 59 -> 0.
- btn_inc in RUN is ignored.
- Blink:
  - blink_phase toggles on every tick_5hz while in a SET state, giving a 2.5 Hz blink.
  - blink_phase is forced to 1 on every state change and on every accepted increment, so the field is lit immediately after an edit.
  - The selected field's *_vis equals blink_phase. All other *_vis are 1. In RUN, all *_vis are 1.
- Timeout:
  - In a SET state, each tick_1hz increments the timeout counter. Any btn_mode or btn_inc clears it.
  - When the counter reaches TIMEOUT_S, the FSM returns to RUN and the counter clears. Edited values are kept.
  - TIMEOUT_S=0 means the FSM never times out.
- Simultaneous events:
  - btn_mode and btn_inc in the same cycle: mode wins, inc is dropped.
  - RUN, tick_1hz and btn_mode in the same cycle: the second increments and the state moves to SET_HR.
  - SET state, timeout expiry and btn_mode in the same cycle: btn_mode wins. The button clears the counter, and the normal transition is taken.
  - SET_SEC, btn_mode and timeout expiry in the same cycle: the FSM goes to RUN either way.
- Reset asserted mid-edit: immediate return to reset values; edits are lost.
- Tick inputs are assumed to be single-cycle pulses. Two ticks are never adjacent (divider guarantee).

Optional Feature:
HOLD_REPEAT_EN
- Defined: in a SET state, after btn_inc_lvl has been held continuously for 5 tick_5hz pulses (about 1 s), each further tick_5hz acts as btn_inc (5 increments/s). Repeat increments also clear the timeout and force blink_phase=1. Releasing btn_inc_lvl resets the hold counter.
- Undefined: btn_inc_lvl is ignored; no hold counter logic is built.

Decomposition:
- Package clock_ctrl_pkg holds:
  - mode state encoding (RUN/SET_HR/SET_MIN/SET_SEC, 2 bits)
  - HOUR_MAX=23, MINSEC_MAX=59
  - field widths 5/6/6
  - REPEAT_HOLD_TICKS=5
- Sub-module hms_counter owns the three time registers. Its inputs:
  - run_tick (cascaded increment)
  - inc_hr / inc_min / inc_sec (no-carry increments)
  
  It outputs hour/minute/second and day_tick.
- clock_mode_ctrl keeps the FSM, blink, timeout and repeat logic.

Test Plan:
- Reset, then 60 tick_1hz pulses in RUN -> time 00:01:00; day_tick never asserted.
- Preload 23:59:58 via SET, return to RUN, 2 tick_1hz -> 00:00:00 and day_tick high exactly 1 clk on the second tick.
- btn_mode once, btn_inc x25 -> mode=1, hour advances 0..23 then wraps to 1. tick_1hz pulses are ignored (second unchanged). hr_vis toggles on each tick_5hz; min_vis and sec_vis stay 1.
- SET_MIN with TIMEOUT_S=30: 29 tick_1hz, btn_inc, then 30 tick_1hz -> exits to RUN only on the 30th tick after the press. The edited minute is retained.
- btn_mode and btn_inc in the same cycle in SET_HR -> mode=2, hour unchanged. tick_1hz and btn_mode in the same cycle in RUN -> second+1 and mode=1.
- HOLD_REPEAT_EN defined: SET_SEC, btn_inc_lvl high for 15 tick_5hz -> 10 increments after the 5-tick hold. Release, then 5 more tick_5hz -> no further increments.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the digital clock mode/timekeeping controller.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } mode_t;

  localparam int unsigned HR_W   = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned SEC_W  = 6;

  localparam logic [HR_W-1:0]  HOUR_MAX   = 5'd23;
  localparam logic [MIN_W-1:0] MINSEC_MAX = 6'd59;

  localparam int unsigned REPEAT_HOLD_TICKS = 5;
  localparam int unsigned HOLD_W            = 3;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      RUN:     return SET_HR;
      SET_HR:  return SET_MIN;
      SET_MIN: return SET_SEC;
      default: return RUN;
    endcase
  endfunction

endpackage

// File: rtl/hms_counter.sv
// hh:mm:ss time registers: cascaded run increment or per-field no-carry edits.
module hms_counter
  import clock_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_tick,
  input  logic             inc_hr,
  input  logic             inc_min,
  input  logic             inc_sec,
  output logic [HR_W-1:0]  hour,
  output logic [MIN_W-1:0] minute,
  output logic [SEC_W-1:0] second,
  output logic             day_tick
);

  logic sec_wrap, min_wrap, hr_wrap;

  assign sec_wrap = (second == MINSEC_MAX);
  assign min_wrap = (minute == MINSEC_MAX);
  assign hr_wrap  = (hour == HOUR_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour     <= '0;
      minute   <= '0;
      second   <= '0;
      day_tick <= 1'b0;
    end else begin
      day_tick <= run_tick && sec_wrap && min_wrap && hr_wrap;
      if (run_tick) begin
        second <= sec_wrap ? '0 : second + 1'b1;
        if (sec_wrap) begin
          minute <= min_wrap ? '0 : minute + 1'b1;
          if (min_wrap)
            hour <= hr_wrap ? '0 : hour + 1'b1;
        end
      end else begin
        if (inc_hr)  hour   <= hr_wrap  ? '0 : hour + 1'b1;
        if (inc_min) minute <= min_wrap ? '0 : minute + 1'b1;
        if (inc_sec) second <= sec_wrap ? '0 : second + 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_mode_ctrl.sv
// RUN/SET mode FSM with field blink, SET-mode inactivity timeout and time registers.
// Optional HOLD_REPEAT_EN: auto-repeat increments while the increment key is held.
module clock_mode_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_S = 30,
  parameter int unsigned TO_W      = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_1hz,
  input  logic             tick_5hz,
  input  logic             btn_mode,
  input  logic             btn_inc,
  input  logic             btn_inc_lvl,
  output logic [HR_W-1:0]  hour,
  output logic [MIN_W-1:0] minute,
  output logic [SEC_W-1:0] second,
  output logic [1:0]       mode,
  output logic             hr_vis,
  output logic             min_vis,
  output logic             sec_vis,
  output logic             day_tick
);

  localparam logic [TO_W:0] TO_LIM = (TO_W+1)'(TIMEOUT_S);

  mode_t           state, state_nx;
  logic [TO_W-1:0] to_cnt, to_nx;
  logic            blink_phase, blink_nx;
  logic            in_set, rep_inc, inc_ok, expire;

  assign in_set = (state != RUN);
  assign expire = (TIMEOUT_S != 0) && tick_1hz &&
                  (({1'b0, to_cnt} + 1'b1) == TO_LIM);

`ifdef HOLD_REPEAT_EN
  logic [HOLD_W-1:0] hold_cnt;

  assign rep_inc = in_set && btn_inc_lvl && tick_5hz &&
                   (hold_cnt == HOLD_W'(REPEAT_HOLD_TICKS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hold_cnt <= '0;
    else if (!in_set || !btn_inc_lvl)
      hold_cnt <= '0;
    else if (tick_5hz && hold_cnt != HOLD_W'(REPEAT_HOLD_TICKS))
      hold_cnt <= hold_cnt + 1'b1;
  end
`else
  logic unused_lvl;
  assign unused_lvl = btn_inc_lvl;
  assign rep_inc    = 1'b0;
`endif

  // btn_mode outranks both increments and timeout expiry; any accepted edit
  // clears the timeout and relights the field before the blink toggle applies.
  always_comb begin
    state_nx = state;
    to_nx    = to_cnt;
    blink_nx = blink_phase;
    inc_ok   = 1'b0;
    if (btn_mode) begin
      state_nx = next_mode(state);
      to_nx    = '0;
      blink_nx = 1'b1;
    end else if (in_set) begin
      if (btn_inc || rep_inc) begin
        inc_ok   = 1'b1;
        to_nx    = '0;
        blink_nx = 1'b1;
      end else begin
        if (tick_5hz)
          blink_nx = ~blink_phase;
        if (expire) begin
          state_nx = RUN;
          to_nx    = '0;
          blink_nx = 1'b1;
        end else if (tick_1hz && TIMEOUT_S != 0) begin
          to_nx = to_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      to_cnt      <= '0;
      blink_phase <= 1'b1;
      hr_vis      <= 1'b1;
      min_vis     <= 1'b1;
      sec_vis     <= 1'b1;
    end else begin
      state       <= state_nx;
      to_cnt      <= to_nx;
      blink_phase <= blink_nx;
      hr_vis      <= (state_nx == SET_HR)  ? blink_nx : 1'b1;
      min_vis     <= (state_nx == SET_MIN) ? blink_nx : 1'b1;
      sec_vis     <= (state_nx == SET_SEC) ? blink_nx : 1'b1;
    end
  end

  assign mode = state;

  hms_counter u_hms (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_tick (tick_1hz && state == RUN),
    .inc_hr   (inc_ok && state == SET_HR),
    .inc_min  (inc_ok && state == SET_MIN),
    .inc_sec  (inc_ok && state == SET_SEC),
    .hour     (hour),
    .minute   (minute),
    .second   (second),
    .day_tick (day_tick)
  );

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Self-checking bench for clock_mode_ctrl against a time-of-day reference model.
// Exercises HOLD_REPEAT_EN auto-repeat when that macro is defined.
module tb_clock_mode_ctrl;

  localparam int TIMEOUT = 30;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1hz, tick_5hz, btn_mode, btn_inc, btn_inc_lvl;
  logic [4:0] hour;
  logic [5:0] minute, second;
  logic [1:0] mode;
  logic       hr_vis, min_vis, sec_vis, day_tick;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: plain integers, time kept as seconds-of-day for RUN
  int m_h, m_m, m_s, m_mode, m_blink, m_to, m_hold, m_day;

  clock_mode_ctrl #(.TIMEOUT_S(TIMEOUT), .TO_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_1hz    (tick_1hz),
    .tick_5hz    (tick_5hz),
    .btn_mode    (btn_mode),
    .btn_inc     (btn_inc),
    .btn_inc_lvl (btn_inc_lvl),
    .hour        (hour),
    .minute      (minute),
    .second      (second),
    .mode        (mode),
    .hr_vis      (hr_vis),
    .min_vis     (min_vis),
    .sec_vis     (sec_vis),
    .day_tick    (day_tick)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_blink = 1; m_to = 0; m_hold = 0; m_day = 0;
  endtask

  task automatic model_step(input bit t1, input bit t5, input bit bm, input bit bi, input bit lvl);
    int tod;
    bit rep;
    rep   = 0;
    m_day = 0;
`ifdef HOLD_REPEAT_EN
    if (m_mode != 0 && lvl) begin
      if (t5) begin
        if (m_hold >= 5) rep = 1;
        else m_hold++;
      end
    end else begin
      m_hold = 0;
    end
`endif
    if (m_mode == 0 && t1) begin
      tod = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
      m_h = tod / 3600;
      m_m = (tod / 60) % 60;
      m_s = tod % 60;
      m_day = (tod == 0);
    end
    if (bm) begin
      m_mode  = (m_mode + 1) % 4;
      m_to    = 0;
      m_blink = 1;
    end else if (m_mode != 0) begin
      if (bi || rep) begin
        case (m_mode)
          1: m_h = (m_h + 1) % 24;
          2: m_m = (m_m + 1) % 60;
          default: m_s = (m_s + 1) % 60;
        endcase
        m_to    = 0;
        m_blink = 1;
      end else begin
        if (t5) m_blink = !m_blink;
        if (t1 && TIMEOUT > 0) begin
          m_to++;
          if (m_to == TIMEOUT) begin
            m_mode  = 0;
            m_to    = 0;
            m_blink = 1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    check("hour",     int'(hour),     m_h);
    check("minute",   int'(minute),   m_m);
    check("second",   int'(second),   m_s);
    check("mode",     int'(mode),     m_mode);
    check("hr_vis",   int'(hr_vis),   (m_mode == 1) ? m_blink : 1);
    check("min_vis",  int'(min_vis),  (m_mode == 2) ? m_blink : 1);
    check("sec_vis",  int'(sec_vis),  (m_mode == 3) ? m_blink : 1);
    check("day_tick", int'(day_tick), m_day);
  endtask

  // one clock: drive inputs, advance model on the edge, compare 1 time unit later
  task automatic cycle(input bit t1, input bit t5, input bit bm, input bit bi);
    tick_1hz = t1; tick_5hz = t5; btn_mode = bm; btn_inc = bi;
    @(posedge clk);
    model_step(t1, t5, bm, bi, btn_inc_lvl);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
  endtask

  task automatic tick1();      cycle(1, 0, 0, 0); idle(1); endtask
  task automatic tick5();      cycle(0, 1, 0, 0); idle(1); endtask
  task automatic press_mode(); cycle(0, 0, 1, 0); idle(1); endtask
  task automatic press_inc();  cycle(0, 0, 0, 1); idle(1); endtask

  initial begin
    int saved;
    bit prev_tick, t1, t5;

    rst_n = 1'b0;
    tick_1hz = 0; tick_5hz = 0; btn_mode = 0; btn_inc = 0; btn_inc_lvl = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // 60 seconds in RUN
    for (int i = 0; i < 60; i++) tick1();
    check("t60_min", int'(minute), 1);
    check("t60_sec", int'(second), 0);

    // preload 23:59:58 via SET, then roll over the day
    press_mode();
    while (m_h != 23) press_inc();
    press_mode();
    while (m_m != 59) press_inc();
    press_mode();
    while (m_s != 58) press_inc();
    press_mode();
    check("preload_mode", int'(mode), 0);
    tick1();
    cycle(1, 0, 0, 0);
    check("roll_day_tick", int'(day_tick), 1);
    check("roll_hour", int'(hour), 0);
    idle(1);
    check("roll_day_tick_clear", int'(day_tick), 0);

    // SET_HR: 25 increments, ignored 1 Hz ticks, blinking hour field
    press_mode();
    for (int i = 0; i < 25; i++) begin
      press_inc();
      if (i % 3 == 0) tick1();
      tick5();
    end
    check("hr_wrap", int'(hour), 1);
    check("hr_frozen_sec", int'(second), 0);

    // SET_MIN timeout restarts on a press and fires on the 30th tick after it
    press_mode();
    for (int i = 0; i < 29; i++) tick1();
    press_inc();
    saved = int'(minute);
    for (int i = 0; i < 29; i++) tick1();
    check("to_before", int'(mode), 2);
    tick1();
    check("to_exit", int'(mode), 0);
    check("to_keep_min", int'(minute), saved);

    // simultaneous events
    press_mode();
    saved = int'(hour);
    cycle(0, 0, 1, 1);
    check("mode_beats_inc", int'(mode), 2);
    check("mode_beats_inc_hr", int'(hour), saved);
    idle(1);
    press_mode();
    press_mode();
    saved = int'(second);
    cycle(1, 0, 1, 0);
    check("tick_and_mode_sec", int'(second), (saved + 1) % 60);
    check("tick_and_mode_mode", int'(mode), 1);
    idle(1);

`ifdef HOLD_REPEAT_EN
    press_mode();
    press_mode();
    saved = int'(second);
    btn_inc_lvl = 1'b1;
    for (int i = 0; i < 15; i++) tick5();
    check("hold_repeat", int'(second), (saved + 10) % 60);
    btn_inc_lvl = 1'b0;
    idle(1);
    for (int i = 0; i < 5; i++) tick5();
    check("hold_release", int'(second), (saved + 10) % 60);
    press_mode();
`endif

    // randomized traffic; ticks never in adjacent cycles
    prev_tick = 0;
    for (int i = 0; i < 3000; i++) begin
      t1 = !prev_tick && ($urandom_range(0, 7) == 0);
      t5 = !prev_tick && !t1 && ($urandom_range(0, 3) == 0);
      prev_tick = t1 || t5;
      if ($urandom_range(0, 19) == 0) btn_inc_lvl = !btn_inc_lvl;
      cycle(t1, t5, $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0);
    end

    // reset in the middle of an edit returns everything at once
    btn_inc_lvl = 1'b0;
    while (m_mode != 1) press_mode();
    press_inc();
    press_inc();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
